// File: rtl/logic_reduce_pkg.sv
// Shared types and helpers for the logic reduction unit.
//   op_t    : gate select encoding carried on in_op
//   state_t : frame FSM states
//   base_of : maps any op to the AND/OR/XOR it accumulates with
//   inverts : ops whose final frame result is complemented
//   is_rsv  : ops 6/7, which yield a zero result with the error flag set
package logic_reduce_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic op_t base_of(input op_t op);
    case (op)
      OP_OR, OP_NOR:   base_of = OP_OR;
      OP_XOR, OP_XNOR: base_of = OP_XOR;
      default:         base_of = OP_AND;
    endcase
  endfunction

  function automatic logic inverts(input op_t op);
    case (op)
      OP_NAND, OP_NOR, OP_XNOR: inverts = 1'b1;
      default:                  inverts = 1'b0;
    endcase
  endfunction

  function automatic logic is_rsv(input op_t op);
    is_rsv = (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/logic_reduce_unit_if.sv
// Handshake bundle of the logic reduction unit.
//   in_valid/in_ready/in_data/in_op/in_last : operand beat stream
//   out_valid/out_ready/out_data/out_count/out_err : frame result stream
// master = producer/consumer side (testbench), slave = reduction unit.
interface logic_reduce_unit_if #(
  parameter int WIDTH = 8,
  parameter int NIN   = 3,
  parameter int CNTW  = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NIN*WIDTH-1:0] in_data;
  logic [2:0]           in_op;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CNTW-1:0]      out_count;
  logic                 out_err;

  modport master (
    output in_valid, in_data, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_err
  );

  modport slave (
    input  in_valid, in_data, in_op, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_err
  );
endinterface

// File: rtl/logic_reduce_unit_reduce_gate.sv
// Purely combinational bitwise reduction of NIN operands with a base op.
//   base_op : OP_AND, OP_OR or OP_XOR (anything else reduces as AND)
//   data    : NIN operands, operand k = data[k*WIDTH +: WIDTH]
//   res     : bitwise reduction result
module reduce_gate
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 3
) (
  input  op_t                  base_op,
  input  logic [NIN*WIDTH-1:0] data,
  output logic [WIDTH-1:0]     res
);

  logic [WIDTH-1:0] fold_s;

  // Fold the operands left to right with the selected base op.
  always_comb begin
    fold_s = data[WIDTH-1:0];
    for (int k = 1; k < NIN; k++) begin
      case (base_op)
        OP_OR:   fold_s = fold_s | data[k*WIDTH +: WIDTH];
        OP_XOR:  fold_s = fold_s ^ data[k*WIDTH +: WIDTH];
        default: fold_s = fold_s & data[k*WIDTH +: WIDTH];
      endcase
    end
  end

  assign res = fold_s;

endmodule

// File: rtl/logic_reduce_unit.sv
// Gate/reduction engine: reduces NIN operands per beat and all beats of a
// frame (delimited by in_last) with a gate selected on the first beat.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of logic_reduce_unit_if (beat in, result out)
// One registered result per frame; out_count saturates at 2^CNTW-1.
module logic_reduce_unit
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 3,
  parameter int CNTW  = 4
) (
  input logic                clk,
  input logic                reset,
  logic_reduce_unit_if.slave bus
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t           state_r, state_nxt_s;
  op_t              op_r, cur_op_s, base_s;
  logic [WIDTH-1:0] acc_r, acc_nxt_s, beat_res_s, comb_res_s, result_s;
  logic [CNTW-1:0]  cnt_r, cnt_nxt_s;
  logic             out_valid_r, out_err_r, err_s;
  logic [WIDTH-1:0] out_data_r;
  logic [CNTW-1:0]  out_count_r;
  logic             in_ready_s, accept_s, first_s;

  assign in_ready_s = ~reset & (~out_valid_r | bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s;
  // Any beat accepted outside ACCUM opens a new frame.
  assign first_s    = (state_r != ACCUM);

  // The op of the first beat comes straight from the bus; later beats use the latched op.
  always_comb begin
    if (first_s) begin
      cur_op_s = op_t'(bus.in_op);
    end else begin
      cur_op_s = op_r;
    end
    base_s = base_of(cur_op_s);
  end

  reduce_gate #(.WIDTH(WIDTH), .NIN(NIN)) u_beat_gate (
    .base_op (base_s),
    .data    (bus.in_data),
    .res     (beat_res_s)
  );

  reduce_gate #(.WIDTH(WIDTH), .NIN(2)) u_acc_gate (
    .base_op (base_s),
    .data    ({acc_r, beat_res_s}),
    .res     (comb_res_s)
  );

  // Next accumulator and saturating beat count for an accepted beat.
  always_comb begin
    if (first_s) begin
      acc_nxt_s = beat_res_s;
      cnt_nxt_s = CNTW'(1);
    end else if (cnt_r == CNT_MAX) begin
      acc_nxt_s = comb_res_s;
      cnt_nxt_s = cnt_r;
    end else begin
      acc_nxt_s = comb_res_s;
      cnt_nxt_s = cnt_r + CNTW'(1);
    end
  end

  // Final frame result: inversion is applied once, after accumulation.
  always_comb begin
    if (is_rsv(cur_op_s)) begin
      result_s = {WIDTH{1'b0}};
      err_s    = 1'b1;
    end else if (inverts(cur_op_s)) begin
      result_s = ~acc_nxt_s;
      err_s    = 1'b0;
    end else begin
      result_s = acc_nxt_s;
      err_s    = 1'b0;
    end
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_nxt_s = bus.in_last ? DONE : ACCUM;
        end else if (state_r == DONE && bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ACCUM: begin
        if (accept_s && bus.in_last) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, frame accumulator and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      op_r        <= OP_AND;
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNTW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_count_r <= {CNTW{1'b0}};
      out_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
      if (accept_s) begin
        op_r  <= cur_op_s;
        acc_r <= acc_nxt_s;
        cnt_r <= cnt_nxt_s;
        if (bus.in_last) begin
          out_data_r  <= result_s;
          out_count_r <= cnt_nxt_s;
          out_err_r   <= err_s;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_count = out_count_r;
  assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Scoreboard bench for logic_reduce_unit (WIDTH=8, NIN=3, CNTW=2).
module tb_logic_reduce_unit;
  localparam int WIDTH = 8;
  localparam int NIN   = 3;
  localparam int CNTW  = 2;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] count;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic_reduce_unit_if #(.WIDTH(WIDTH), .NIN(NIN), .CNTW(CNTW)) bus ();

  logic_reduce_unit #(.WIDTH(WIDTH), .NIN(NIN), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  logic [7:0] frame_q[$];
  int         frame_op    = 0;
  int         frame_beats = 0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_pop = -10;
  int         prev_pop = -20;
  int         acc_cyc = -1;
  bit         rnd_ready = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] held_data;
  logic [1:0] held_cnt;
  logic       held_err;
  exp_t       mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: fold every operand of every beat with the frame's gate.
  function automatic exp_t model(input int op, input logic [7:0] ops[$], input int nbeats);
    exp_t e;
    logic [7:0] r;
    r = ops[0];
    for (int i = 1; i < ops.size(); i++) begin
      case (op % 3)
        0:       r = r & ops[i];
        1:       r = r | ops[i];
        default: r = r ^ ops[i];
      endcase
    end
    if (op >= 6) begin
      e.data = 8'h00;
      e.err  = 1'b1;
    end else begin
      e.data = (op >= 3) ? ~r : r;
      e.err  = 1'b0;
    end
    e.count = (nbeats > 3) ? 2'd3 : 2'(nbeats);
    return e;
  endfunction

  // Monitor: pop and compare on every result handshake; check hold during stalls.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, held_data);
        check("hold_count", bus.out_count, held_cnt);
        check("hold_err", bus.out_err, held_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", bus.out_data, mon_e.data);
          check("out_count", bus.out_count, mon_e.count);
          check("out_err", bus.out_err, mon_e.err);
        end
        prev_pop = last_pop;
        last_pop = cyc;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_data  = bus.out_data;
      held_cnt   = bus.out_count;
      held_err   = bus.out_err;
    end
  end

  // Drive one beat starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic beat(input logic [23:0] d, input logic [2:0] op, input logic last);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_op    = op;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("beat_accept_timeout", 0, 1);
    end else begin
      acc_cyc = cyc;
      if (frame_beats == 0) frame_op = int'(op);
      frame_beats++;
      for (int k = 0; k < NIN; k++) frame_q.push_back(d[k*8 +: 8]);
      if (last) begin
        exp_q.push_back(model(frame_op, frame_q, frame_beats));
        frame_q.delete();
        frame_beats = 0;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int op;
    int nb;
    int waited;
    logic [23:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = 24'h0;
    bus.in_op     = 3'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    idle(2);

    // Reset state, with a valid beat offered during reset.
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_data  = 24'hFFFFFF;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_count", bus.out_count, 0);
    check("reset_out_err", bus.out_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("no_result_from_reset_beat", bus.out_valid, 0);
    idle(1);

    // Single-beat AND with one-cycle latency.
    beat({8'hFF, 8'h3C, 8'hF0}, 3'd0, 1'b1);
    @(negedge clk);
    check("and_latency_valid", bus.out_valid, 1);
    idle(1);

    // NAND over three beats; op on beat 2 must be ignored.
    beat({8'hFF, 8'hFF, 8'hFF}, 3'd3, 1'b0);
    beat({8'hFF, 8'hFF, 8'h0F}, 3'd1, 1'b0);
    beat({8'hFF, 8'hFE, 8'hFF}, 3'd1, 1'b1);
    idle(2);

    // XOR then XNOR back to back.
    beat({8'h04, 8'h02, 8'h01}, 3'd2, 1'b1);
    beat({8'h04, 8'h02, 8'h01}, 3'd5, 1'b1);
    idle(2);
    check("b2b_consecutive", 32'(last_pop - prev_pop), 1);

    // Backpressure: pending result held for 4 cycles.
    bus.out_ready = 1'b0;
    beat({8'hAA, 8'h0F, 8'hF3}, 3'd1, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready_low", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    beat({8'h81, 8'h42, 8'h24}, 3'd4, 1'b1);
    check("bp_same_cycle", 32'(last_pop - acc_cyc), 0);
    idle(2);

    // Reset mid-frame discards the partial frame.
    beat({8'hFF, 8'hFF, 8'hFF}, 3'd1, 1'b0);
    beat({8'hFF, 8'h00, 8'hFF}, 3'd1, 1'b0);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    frame_q.delete();
    frame_beats = 0;
    beat({8'h00, 8'h00, 8'h01}, 3'd1, 1'b1);
    idle(2);

    // Reserved op, then counter saturation.
    beat({8'h12, 8'h34, 8'h56}, 3'd6, 1'b1);
    for (int i = 0; i < 5; i++) beat(24'hFFFFFF, 3'd0, (i == 4) ? 1'b1 : 1'b0);
    idle(2);

    // Randomized frames with random gaps and random backpressure.
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      op = int'($urandom_range(0, 7));
      nb = int'($urandom_range(1, 5));
      for (int b = 0; b < nb; b++) begin
        d = 24'($urandom);
        if (op % 3 == 0) d = d | 24'($urandom) | 24'($urandom);
        beat(d, (b == 0) ? 3'(op) : 3'($urandom_range(0, 7)), (b == nb - 1) ? 1'b1 : 1'b0);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      idle(1);
      waited++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_reduce_unit.md
Name: logic_reduce_unit

Overview:
- Parametrised successor of the fixed 3-input gate modules. Bitwise-reduces NIN operands of WIDTH bits each with a runtime-selected gate function (AND/OR/XOR and their inversions).
- Also reduces across a multi-beat frame delimited by in_last, producing one registered result per frame.
- Uses valid/ready handshakes on both sides. Sits between operand producers and downstream datapath logic as a reusable gate/reduction engine.

Parameters:
- WIDTH, 8, bits per operand and result.
- NIN, 3, operands per beat (>=2).
- CNTW, 4, width of the saturating beat counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_data  input  NIN*WIDTH  operands; operand k = in_data[k*WIDTH +: WIDTH].
- in_op  input  3  gate select, sampled on the first beat of a frame.
- in_last  input  1  marks the final beat of a frame.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  frame result.
- out_count  output  CNTW  beats in frame, saturating.
- out_err  output  1  frame used a reserved op.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- Base op: AND for 0/3, OR for 1/4, XOR for 2/5. Inversion applies only once, to the final frame result, never per beat.
- Per-beat combine: bitwise base-op across the NIN operands gives beat_res.
- Frame accumulation: acc = beat_res on the first beat, then acc = acc base-op beat_res on each later beat.
- Result on the last beat: out_data = acc, or ~acc for ops 3/4/5.
- Reserved op: out_data = 0 and out_err = 1; beats are still consumed normally until in_last.
- Op latching: in_op is captured in op_q on the first accepted beat of a frame. in_op on later beats is ignored.
- FSM states:
  - IDLE: no frame open. An accepted beat with in_last=0 goes to ACCUM; an accepted beat with in_last=1 goes to DONE.
  - ACCUM: accepted beats update acc and the count. An accepted beat with in_last=1 goes to DONE.
  - DONE: out_valid=1. When out_ready=1 the result is taken. If a new beat is accepted in the same cycle, it starts the next frame (ACCUM, or DONE again if in_last=1). Otherwise go to IDLE.
- Handshake:
  - in_ready = ~reset & (~out_valid | out_ready).
  - Every beat is held off while a result is pending and not being taken.
  - out_data, out_count and out_err stay stable while out_valid & ~out_ready.
- Latency: result registered; out_valid rises the cycle after the last beat is accepted. Sustained throughput is one single-beat frame per cycle when out_ready=1.
- Counter: out_count = number of beats accepted in the frame, saturating at 2^CNTW-1. It resets to 1 on the first beat of each frame.
- Reset values: out_valid 0, out_data 0, out_count 0, out_err 0, op_q 0, acc 0, state IDLE.
- Reset mid-frame: the partial frame is discarded and no result is emitted. The next accepted beat starts a fresh frame.
- Reset with out_valid=1: the result is dropped.
- Reset beat: in_ready is 0 during the reset cycle, so no beat is accepted in that cycle.

Decomposition:
- Package logic_reduce_pkg holds:
  - op_t enum (OP_AND .. OP_XNOR, OP_RSV6, OP_RSV7);
  - state_t enum (IDLE, ACCUM, DONE);
  - functions base_of(op_t) and inverts(op_t).
- Sub-module reduce_gate (parameters WIDTH, NIN): a purely combinational bitwise base-op reduction across NIN operands. It is instantiated for the per-beat combine. The accumulate step reuses the same function with NIN=2.

Test Plan:
- Single-beat AND (WIDTH=8, NIN=3): F0,3C,FF, in_last=1, op=0 -> next cycle out_valid=1, out_data=30, out_count=1, out_err=0.
- NAND 3-beat frame: beats (FF,FF,FF), (0F,FF,FF), (FF,FE,FF); op=3 on beat 1 and op=1 on beat 2 (must be ignored) -> out_data=F1, out_count=3.
- XOR/XNOR: one beat 01,02,04 with op=2 -> out_data=07; repeat with op=5 -> out_data=F8. Back-to-back with out_ready=1 -> results on consecutive cycles.
- Backpressure: result pending with out_ready=0 for 4 cycles -> in_ready=0, out_data stable. Raising out_ready together with a new valid beat -> result taken and new beat accepted in the same cycle.
- Reset mid-frame: 2 OR beats (FF,...), then a 1-cycle reset, then one beat OR 00,00,01 with last -> out_data=01, out_count=1; no result emitted for the aborted frame.
- Reserved op and saturation (CNTW=2): op=6, single beat -> out_data=00, out_err=1. Then op=0 with 5 beats of FF -> out_data=FF, out_count=3, out_err=0.
